// File: rtl/diff_freq_serial_in.sv
// diff_freq_serial_in: dual-rate serial word receiver, LSB first, with a 2-flop input synchronizer.
// Optional macro RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of three mid-bit samples.
module diff_freq_serial_in #(
  parameter int DATA_BIT     = 16,
  parameter int TICK_PER_BIT = 16,
  parameter int TICK_10K_HZ  = 63,
  parameter int TICK_20K_HZ  = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_sel_freq,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_serial,
  output logic                o_bit_tick,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_busy,
  output logic                o_done_tick
);

  localparam int LO_W = (TICK_10K_HZ > 1) ? $clog2(TICK_10K_HZ) : 1;
  localparam int HI_W = (TICK_20K_HZ > 1) ? $clog2(TICK_20K_HZ) : 1;
  localparam int TW   = $clog2(TICK_PER_BIT);
  localparam int BW   = $clog2(DATA_BIT + 1);

  localparam logic [LO_W-1:0] LO_LAST   = LO_W'(TICK_10K_HZ - 1);
  localparam logic [HI_W-1:0] HI_LAST   = HI_W'(TICK_20K_HZ - 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_PER_BIT - 1);
  localparam logic [TW-1:0]   TICK_MID  = TW'(TICK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BIT - 1);

  typedef enum logic {IDLE, DATA} state_e;

  state_e              state_q, state_d;
  logic [LO_W-1:0]     lo_cnt_q, lo_cnt_d;
  logic [HI_W-1:0]     hi_cnt_q, hi_cnt_d;
  logic [1:0]          sync_q, sync_d;
  logic                sel_q, sel_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                bit_tick_q, bit_tick_d;
  logic                done_tick_q, done_tick_d;

  logic tick_lo, tick_hi, active_tick, rx_bit;

  assign tick_lo     = (lo_cnt_q == LO_LAST);
  assign tick_hi     = (hi_cnt_q == HI_LAST);
  assign active_tick = sel_q ? tick_hi : tick_lo;
  assign rx_bit      = sync_q[1];

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q, vote_d;
  logic       vote_bit;
  assign vote_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_bit) | (vote_q[1] & rx_bit);
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch below can infer a latch.
    lo_cnt_d    = tick_lo ? '0 : lo_cnt_q + LO_W'(1);
    hi_cnt_d    = tick_hi ? '0 : hi_cnt_q + HI_W'(1);
    sync_d      = {sync_q[0], i_serial};
    state_d     = state_q;
    sel_d       = sel_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    bit_tick_d  = 1'b0;
    done_tick_d = 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
    vote_d      = vote_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          state_d    = DATA;
          sel_d      = i_sel_freq;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      DATA: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (active_tick) begin
          // Sampling looks at the pre-increment tick count.
`ifdef RX_MAJORITY_VOTE_EN
          if (tick_cnt_q == TICK_MID - TW'(1)) vote_d[0] = rx_bit;
          if (tick_cnt_q == TICK_MID)          vote_d[1] = rx_bit;
          if (tick_cnt_q == TICK_MID + TW'(1)) shift_d = {vote_bit, shift_q[DATA_BIT-1:1]};
`else
          if (tick_cnt_q == TICK_MID) shift_d = {rx_bit, shift_q[DATA_BIT-1:1]};
`endif
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            bit_tick_d = 1'b1;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              data_d      = shift_q;
              done_tick_d = 1'b1;
              state_d     = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments only; the shift register is reset too so an aborted word never lingers.
    if (!rst_n) begin
      state_q     <= IDLE;
      lo_cnt_q    <= '0;
      hi_cnt_q    <= '0;
      sync_q      <= '0;
      sel_q       <= 1'b0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      bit_tick_q  <= 1'b0;
      done_tick_q <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
      vote_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lo_cnt_q    <= lo_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      sync_q      <= sync_d;
      sel_q       <= sel_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      bit_tick_q  <= bit_tick_d;
      done_tick_q <= done_tick_d;
`ifdef RX_MAJORITY_VOTE_EN
      vote_q      <= vote_d;
`endif
    end
  end

  assign o_bit_tick  = bit_tick_q;
  assign o_data      = data_q;
  assign o_busy      = (state_q == DATA);
  assign o_done_tick = done_tick_q;

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Self-checking bench for diff_freq_serial_in: frame timing is predicted from free-running
// tick phases, received words are compared with the words the bench transmitted.
module tb_diff_freq_serial_in;

  localparam int DATA_BIT    = 16;
  localparam int TPB         = 16;
  localparam int M_LO        = 4;
  localparam int M_HI        = 2;
  localparam int FRAME_TICKS = DATA_BIT * TPB;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_STOP   = 2;
  localparam int MODE_RESET  = 3;
  localparam int MODE_REPEAT = 4;
  localparam int MODE_GLITCH = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_sel_freq = 1'b0;
  logic                i_start = 1'b0;
  logic                i_stop = 1'b0;
  logic                i_serial = 1'b0;
  logic                o_bit_tick;
  logic [DATA_BIT-1:0] o_data;
  logic                o_busy;
  logic                o_done_tick;

  int errors = 0;
  int checks = 0;
  logic [DATA_BIT-1:0] exp_data;

  // Observations of the most recent frame.
  int   r_nbt, r_ndone, r_done_c, r_exp_done_c, r_gap_err, r_nbt_at_done;
  logic r_busy_fall;
  logic [DATA_BIT-1:0] r_data;

  // Model of the two free-running divider phases (value before the next rising edge).
  int ph_lo = 0;
  int ph_hi = 0;

  diff_freq_serial_in #(
    .DATA_BIT    (DATA_BIT),
    .TICK_PER_BIT(TPB),
    .TICK_10K_HZ (M_LO),
    .TICK_20K_HZ (M_HI)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sel_freq (i_sel_freq),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_serial   (i_serial),
    .o_bit_tick (o_bit_tick),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done_tick(o_done_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph_lo <= 0;
      ph_hi <= 0;
    end else begin
      ph_lo <= (ph_lo + 1) % M_LO;
      ph_hi <= (ph_hi + 1) % M_HI;
    end
  end

  // Drives one frame starting at the next edge. Iteration c observes outputs registered
  // by edge E+c-1 and sets inputs for edge E+c, where E is the start-accepting edge.
  task automatic run_frame(input logic [DATA_BIT-1:0] word, input logic sel, input int mode);
    int m, ph_e, off, limit, last_bt, abort_c, k, cc;
    m = sel ? M_HI : M_LO;
    @(negedge clk);
    ph_e = sel ? ph_hi : ph_lo;
    // First counted tick after E lands 'off' edges later; tick j lands at m*j+off.
    off = (ph_e == m - 1) ? m : (m - 1 - ph_e);
    r_exp_done_c  = m * (FRAME_TICKS - 1) + off + 1;
    limit         = r_exp_done_c + 6;
    r_nbt         = 0;
    r_ndone       = 0;
    r_done_c      = -1;
    r_gap_err     = 0;
    r_nbt_at_done = -1;
    r_busy_fall   = 1'b1;
    last_bt       = -1;
    abort_c       = -1;
    i_start    = 1'b1;
    i_stop     = 1'b0;
    i_sel_freq = sel;
    i_serial   = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      i_start = (mode == MODE_REPEAT) && (c < r_exp_done_c - 8) && (c % 37 == 0);
      i_stop  = 1'b0;
      if (mode == MODE_TOGGLE) i_sel_freq = ((c / 50) % 2 == 0) ? sel : ~sel;
      if (o_bit_tick === 1'b1) begin
        r_nbt++;
        if (last_bt >= 0 && (c - last_bt) != m * TPB) r_gap_err++;
        last_bt = c;
      end
      if (o_done_tick === 1'b1) begin
        r_ndone++;
        r_done_c      = c;
        r_nbt_at_done = r_nbt;
      end
      if (abort_c >= 0 && c == abort_c + 1) begin
        r_busy_fall = (o_busy === 1'b0) && (o_bit_tick === 1'b0) && (o_done_tick === 1'b0);
        rst_n = 1'b1;
      end
      if (abort_c < 0 && mode == MODE_STOP && r_nbt == 8) begin
        i_stop  = 1'b1;
        abort_c = c;
      end
      if (abort_c < 0 && mode == MODE_RESET && r_nbt == 10) begin
        rst_n   = 1'b0;
        abort_c = c;
      end
      k = c / (m * TPB);
      if (k > DATA_BIT - 1) k = DATA_BIT - 1;
      if (mode == MODE_GLITCH) begin
        cc = c + 2 - off;
        i_serial = (cc >= 0) && (cc % m == 0) && ((cc / m) % TPB == TPB / 2 - 1);
      end else begin
        i_serial = word[k];
      end
      if (abort_c >= 0 && c >= abort_c + 20) break;
    end
    i_start  = 1'b0;
    i_stop   = 1'b0;
    i_serial = 1'b0;
    r_data   = o_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b1; i_stop = 1'b0; i_serial = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0000", o_data); end
    checks++; if (o_bit_tick !== 1'b0) begin errors++; $display("FAIL reset_bit_tick: got %b want 0", o_bit_tick); end
    checks++; if (o_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done_tick: got %b want 0", o_done_tick); end
    i_start = 1'b0; i_serial = 1'b0; rst_n = 1'b1;
    exp_data = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_low_rate();
    run_frame(16'hA5C3, 1'b0, MODE_NORMAL);
    exp_data = 16'hA5C3;
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL low_data: got %h want %h", r_data, exp_data); end
    checks++; if (r_ndone != 1) begin errors++; $display("FAIL low_done_count: got %0d want 1", r_ndone); end
    checks++; if (r_nbt != DATA_BIT) begin errors++; $display("FAIL low_bit_ticks: got %0d want %0d", r_nbt, DATA_BIT); end
    checks++; if (r_nbt_at_done != DATA_BIT) begin errors++; $display("FAIL low_ticks_at_done: got %0d want %0d", r_nbt_at_done, DATA_BIT); end
    checks++; if (r_done_c != r_exp_done_c) begin errors++; $display("FAIL low_done_time: got %0d want %0d", r_done_c, r_exp_done_c); end
    checks++; if (r_gap_err != 0) begin errors++; $display("FAIL low_bit_period: %0d gaps differ from %0d clk", r_gap_err, M_LO * TPB); end
  endtask

  task automatic test_high_rate_toggle();
    run_frame(16'h8001, 1'b1, MODE_TOGGLE);
    exp_data = 16'h8001;
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL high_data: got %h want %h", r_data, exp_data); end
    checks++; if (r_ndone != 1) begin errors++; $display("FAIL high_done_count: got %0d want 1", r_ndone); end
    checks++; if (r_done_c != r_exp_done_c) begin errors++; $display("FAIL high_done_time: got %0d want %0d", r_done_c, r_exp_done_c); end
    checks++; if (r_gap_err != 0) begin errors++; $display("FAIL high_bit_period: %0d gaps differ from %0d clk", r_gap_err, M_HI * TPB); end
  endtask

  task automatic test_stop();
    run_frame(16'hFFFF, 1'b0, MODE_STOP);
    checks++; if (r_busy_fall !== 1'b1) begin errors++; $display("FAIL stop_busy_fall: got %b want 1", r_busy_fall); end
    checks++; if (r_ndone != 0) begin errors++; $display("FAIL stop_done_count: got %0d want 0", r_ndone); end
    checks++; if (r_nbt != 8) begin errors++; $display("FAIL stop_bit_ticks: got %0d want 8", r_nbt); end
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL stop_data_hold: got %h want %h", r_data, exp_data); end
  endtask

  task automatic test_reset_mid();
    run_frame(16'($urandom()), 1'($urandom_range(0, 1)), MODE_RESET);
    exp_data = '0;
    checks++; if (r_busy_fall !== 1'b1) begin errors++; $display("FAIL rstmid_busy_fall: got %b want 1", r_busy_fall); end
    checks++; if (r_ndone != 0) begin errors++; $display("FAIL rstmid_done_count: got %0d want 0", r_ndone); end
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL rstmid_data: got %h want %h", r_data, exp_data); end
    run_frame(16'h1234, 1'b0, MODE_NORMAL);
    exp_data = 16'h1234;
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL rstmid_next_data: got %h want %h", r_data, exp_data); end
    checks++; if (r_ndone != 1) begin errors++; $display("FAIL rstmid_next_done: got %0d want 1", r_ndone); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_BIT-1:0] w;
    logic busy_seen;
    w = 16'($urandom());
    run_frame(w, 1'b1, MODE_REPEAT);
    exp_data = w;
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL repeat_data: got %h want %h", r_data, exp_data); end
    checks++; if (r_ndone != 1) begin errors++; $display("FAIL repeat_done_count: got %0d want 1", r_ndone); end
    @(negedge clk);
    i_start = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_stop = 1'b0;
    busy_seen = 1'b0;
    repeat (6) begin
      if (o_busy !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL start_stop_idle: busy got 1 want 0"); end
    checks++; if (o_data !== exp_data) begin errors++; $display("FAIL start_stop_data: got %h want %h", o_data, exp_data); end
  endtask

  task automatic test_glitch();
    logic [DATA_BIT-1:0] want;
`ifdef RX_MAJORITY_VOTE_EN
    want = 16'h0000;
`else
    want = 16'hFFFF;
`endif
    run_frame(16'h0000, 1'b0, MODE_GLITCH);
    exp_data = want;
    checks++; if (r_data !== exp_data) begin errors++; $display("FAIL glitch_data: got %h want %h", r_data, exp_data); end
    checks++; if (r_ndone != 1) begin errors++; $display("FAIL glitch_done_count: got %0d want 1", r_ndone); end
  endtask

  task automatic test_random();
    logic [DATA_BIT-1:0] w;
    logic s;
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      w = 16'($urandom());
      s = 1'($urandom_range(0, 1));
      run_frame(w, s, MODE_NORMAL);
      exp_data = w;
      checks++; if (r_data !== exp_data) begin errors++; $display("FAIL rand%0d_data: got %h want %h", n, r_data, exp_data); end
      checks++; if (r_done_c != r_exp_done_c) begin errors++; $display("FAIL rand%0d_done_time: got %0d want %0d", n, r_done_c, r_exp_done_c); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_low_rate();
    test_high_rate_toggle();
    test_stop();
    test_reset_mid();
    test_back_to_back();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
